debpx_delta_decoder: RTL
========================

// Module: debpx_delta_decoder
// PURPOSE
//  Stage directly downstream of the de-scan stage in the decompressor. Takes the 256-bit
//  bit-plane-XOR word (8 planes x 32 columns) and inverts the plane XOR. Transposes the
//  planes into 32 8-bit deltas, then rebuilds the 32 original bytes by running-sum delta
//  decoding from a base byte, 8 symbols per cycle over 4 beats.
//  Valid/ready on both sides; output feeds the base-delta / line-assembly stage.
// PARAMETERS
//  NUM_SYM   32  symbols per line (fixed; columns per plane)
//  SYM_W     8   bits per symbol (= number of bit planes)
//  SYM_PER_BEAT 8 symbols accumulated per ACC cycle (NUM_SYM/SYM_PER_BEAT = 4 beats)
// PORTS
//  clk      in   1    clock, all state on rising edge
//  rst_n    in   1    asynchronous active-low reset
//  flush_i  in   1    synchronous abort; returns FSM to IDLE
//  valid_i  in   1    bpx_i/base_i valid
//  ready_o  out  1    block can accept (IDLE only)
//  bpx_i    in   256  plane j = bpx_i[(8-j)*32-1 -: 32]; column c of plane j = bpx_i[(8-j)*32-1-c]
//  base_i   in   8    base byte for running sum
//  valid_o  out  1    data_o valid
//  ready_i  in   1    downstream accepts
//  data_o   out  256  symbol k = data_o[255-8k -: 8]
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, beat cnt=0, acc=0, ready_o=1, valid_o=0, data_o=0.
//  Plane inverse (comb, at capture): bp[0]=bpx[0]; bp[j]=bpx[j]^bp[j-1], j=1..7. Plane 0 = MSB.
//  Transpose: delta[c][7-j] = bp[j][c], i.e. plane j gives bit (7-j) of delta c.
//  FSM:
//   IDLE: ready_o=1. valid_i&ready_o -> latch deltas and base into acc, cnt=0 -> ACC.
//   ACC : beat b (cnt=b) computes s[8b+i] = acc + sum(delta[8b..8b+i]) mod 256, i=0..7;
//         writes them into data_o slots 8b..8b+7; acc <= s[8b+7]; cnt++.
//         After beat 3 (cnt==3) -> OUT.
//   OUT : valid_o=1. data_o/valid_o held stable while !ready_i. ready_i -> IDLE, valid_o=0.
//  Arithmetic: 8-bit modulo-256 adds, carries discarded. s[0] = base_i + delta[0].
//  Latency: acceptance edge E0; valid_o high after edge E4 (4 cycles).
//   Throughput: one line per 6 cycles minimum (ready_o only in IDLE; no overlap).
//  ready_o is a pure function of state (no comb path from ready_i or valid_i).
//  flush_i: highest priority over any handshake. Any state -> IDLE, valid_o=0.
//   cnt=0; data_o keeps its value. A valid_i coinciding with flush_i is NOT accepted.
//  Reset mid-operation: async clear as above; partial line is discarded.
//  data_o outside OUT: holds the last written value. Partial writes during ACC are visible,
//   but only meaningful when valid_o=1.
//  bpx_i/base_i are sampled only on the acceptance edge; upstream may change them afterwards.
// TESTING
//  1 bpx_i=0, base_i=8'h5A -> after 4 cycles valid_o=1, all 32 bytes = 8'h5A.
//  2 Plane-inverse check: bpx_i plane0=32'hFFFF_FFFF, others 0, base 0.
//    Gives bp all ones and deltas all 8'hFF. Expect sym k = (0xFF*(k+1)) mod 256,
//    i.e. FF,FE,...,E0.
//  3 Wrap-around: base=8'hF0, single delta[0]=8'h20 (plane2 col0 set, rest making only
//    col0 nonzero) -> sym k = 8'h10 for all k.
//  4 Backpressure: hold ready_i=0 10 cycles in OUT -> valid_o/data_o stable, ready_o=0.
//    Raise ready_i -> IDLE next edge; next line accepted the cycle after.
//  5 flush_i asserted in ACC beat 2 with valid_i=1 -> IDLE next edge, valid_o stays 0.
//    Line not accepted on flush cycle; accepted the following cycle.
//  6 rst_n pulsed low in OUT -> immediate valid_o=0, data_o=0, ready_o=1.
//    A fresh line then decodes correctly.

Source files
------------

// File: rtl/debpx_delta_decoder_if.sv
// Valid/ready bus between the de-scan stage, the delta decoder and the line-assembly stage.
interface debpx_delta_decoder_if;
  localparam int unsigned NUM_SYM = 32;
  localparam int unsigned SYM_W   = 8;
  localparam int unsigned LINE_W  = NUM_SYM * SYM_W;

  // Upstream side: bit-plane-XOR line plus base byte
  logic              valid_i;
  logic              ready_o;
  logic [LINE_W-1:0] bpx_i;
  logic [SYM_W-1:0]  base_i;

  // Downstream side: decoded line
  logic              valid_o;
  logic              ready_i;
  logic [LINE_W-1:0] data_o;

  modport master (
    output valid_i, bpx_i, base_i, ready_i,
    input  ready_o, valid_o, data_o
  );

  modport slave (
    input  valid_i, bpx_i, base_i, ready_i,
    output ready_o, valid_o, data_o
  );
endinterface

// File: rtl/debpx_delta_decoder.sv
// Delta decoder: undoes the bit-plane XOR, transposes planes into per-column deltas and
// rebuilds the 32 symbols with a modulo-256 running sum, 8 symbols per beat over 4 beats.
module debpx_delta_decoder (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  debpx_delta_decoder_if.slave  bus
);

  localparam int unsigned NUM_SYM      = 32;
  localparam int unsigned SYM_W        = 8;
  localparam int unsigned SYM_PER_BEAT = 8;
  localparam int unsigned BEATS        = NUM_SYM / SYM_PER_BEAT;
  localparam int unsigned CNT_W        = 2;
  localparam int unsigned IDX_W        = 5;
  localparam int unsigned LANE_W       = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                                     r_state;
  logic [CNT_W-1:0]                           r_cnt;
  logic [SYM_W-1:0]                           r_acc;
  logic                                       r_ready;
  logic                                       r_valid;
  logic [BEATS-1:0][SYM_PER_BEAT-1:0][SYM_W-1:0] r_delta;
  logic [NUM_SYM-1:0][SYM_W-1:0]              r_data;

  logic [BEATS-1:0][SYM_PER_BEAT-1:0][SYM_W-1:0] w_delta;
  logic [SYM_PER_BEAT-1:0][SYM_W-1:0]         w_sum;

  // Plane inverse (prefix XOR from the MSB plane down) and transpose into column deltas
  always_comb begin : p_delta
    logic [NUM_SYM-1:0] v_bp;
    v_bp    = '0;
    w_delta = '0;
    for (int j = 0; j < SYM_W; j++) begin
      v_bp = v_bp ^ bus.bpx_i[(SYM_W-j)*NUM_SYM-1 -: NUM_SYM];
      for (int c = 0; c < NUM_SYM; c++) begin
        w_delta[c / SYM_PER_BEAT][c % SYM_PER_BEAT][SYM_W-1-j] = v_bp[NUM_SYM-1-c];
      end
    end
  end

  // Running sums for the current beat, seeded by the accumulator
  always_comb begin : p_sum
    logic [SYM_W-1:0] v_run;
    v_run = r_acc;
    w_sum = '0;
    for (int i = 0; i < SYM_PER_BEAT; i++) begin
      v_run    = v_run + r_delta[r_cnt][i];
      w_sum[i] = v_run;
    end
  end

  // Control FSM with registered handshake outputs; flush overrides any handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_delta <= '0;
      r_data  <= '0;
    end else if (flush_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.valid_i && r_ready) begin
            r_delta <= w_delta;
            r_acc   <= bus.base_i;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_state <= S_ACC;
          end
        end
        S_ACC: begin
          for (int i = 0; i < SYM_PER_BEAT; i++) begin
            r_data[IDX_W'(NUM_SYM-1) - {r_cnt, LANE_W'(i)}] <= w_sum[i];
          end
          r_acc <= w_sum[SYM_PER_BEAT-1];
          r_cnt <= CNT_W'(r_cnt + CNT_W'(1));
          if (r_cnt == CNT_W'(BEATS-1)) begin
            r_valid <= 1'b1;
            r_state <= S_OUT;
          end
        end
        S_OUT: begin
          if (bus.ready_i) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_ready <= 1'b1;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready_o = r_ready;
  assign bus.valid_o = r_valid;
  assign bus.data_o  = r_data;

endmodule
